// File: rtl/seg_scan_driver_if.sv
// Load/ready handshake and display bus between a value source and seg_scan_driver.
interface seg_scan_driver_if #(
    parameter int BIN_W  = 6,
    parameter int DIGITS = 2
);
    logic [BIN_W-1:0]  value;
    logic              load;
    logic              ready;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              ovf;

    modport master (output value, load, input ready, seg, an, ovf);
    modport slave  (input value, load, output ready, seg, an, ovf);
endinterface

// File: rtl/seg_scan_driver.sv
// Multi-digit 7-segment driver: serial double-dabble binary-to-BCD conversion
// feeding a time-multiplexed display with one-hot digit enables.
//
// state    | meaning
// ST_IDLE  | ready for a load
// ST_SHIFT | double-dabble, one binary bit per cycle
// ST_DONE  | commit BCD result and overflow flag to the display register
module seg_scan_driver #(
    parameter int BIN_W    = 6,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_driver_if.slave  bus
);

    // Decimal digits needed for 2^BIN_W-1 is ceil(BIN_W*log10(2)).
    localparam int DEC_N  = (BIN_W * 30103 + 99999) / 100000;
    localparam int ACC_N  = (DEC_N > DIGITS) ? DEC_N : DIGITS;
    localparam int ACC_W  = 4 * ACC_N;
    localparam int DISP_W = 4 * DIGITS;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic                ovf_q, ovf_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                upper_nz;
    logic [DIGITS-1:0]   lead_zero;
    logic                nz_seen;
    logic [3:0]          cur_digit;
    logic                cur_lz;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    always_comb begin
        upper_nz = 1'b0;
        for (int i = DIGITS; i < ACC_N; i++) begin
            upper_nz = upper_nz | (acc_q[4*i +: 4] != 4'd0);
        end
    end

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < ACC_N; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (ready_q && bus.load) begin
                    bin_d   = bus.value;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(BIN_W - 1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
                bin_d = bin_q << 1;
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_DONE: begin
                disp_d  = acc_q[DISP_W-1:0];
                ovf_d   = upper_nz;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // A digit is a leading zero when it and every more significant digit is zero.
    always_comb begin
        lead_zero = '0;
        nz_seen   = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_seen      = nz_seen | (disp_q[4*i +: 4] != 4'd0);
            lead_zero[i] = ~nz_seen;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_lz    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = disp_q[4*i +: 4];
                cur_lz    = lead_zero[i];
            end
        end
        an_d = DIGITS'(1) << idx_q;
        if (ovf_q)                                            seg_d = 7'h40;
        else if ((BLANK_LZ != 0) && (idx_q != '0) && cur_lz) seg_d = 7'h00;
        else                                                  seg_d = seg_encode(cur_digit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            div_q   <= '0;
            an_q    <= '0;
            seg_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: three instances covering blanking,
// overflow and scan-rate variants against a decimal-arithmetic reference model.
module tb_seg_scan_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    seg_scan_driver_if #(.BIN_W(6), .DIGITS(2)) if_a ();
    seg_scan_driver_if #(.BIN_W(8), .DIGITS(2)) if_b ();
    seg_scan_driver_if #(.BIN_W(8), .DIGITS(2)) if_c ();

    seg_scan_driver #(.BIN_W(6), .DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    seg_scan_driver #(.BIN_W(8), .DIGITS(2), .SCAN_DIV(3), .BLANK_LZ(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    seg_scan_driver #(.BIN_W(8), .DIGITS(2), .SCAN_DIV(1), .BLANK_LZ(0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    // Reference: what a digit position should show for value v on a display of 'digits'.
    function automatic logic [6:0] model_seg(input int v, input int digits, input int pos,
                                             input bit blank_lz);
        int lim = 1;
        int p = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        for (int i = 0; i < pos; i++) p = p * 10;
        if (v >= lim) return 7'h40;
        if (blank_lz && pos > 0 && v < p) return 7'h00;
        case ((v / p) % 10)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            default: return 7'h6F;
        endcase
    endfunction

    function automatic bit model_ovf(input int v, input int digits);
        int lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        return v >= lim;
    endfunction

    task automatic load_a(input int v, output bit accepted);
        @(negedge clk);
        accepted   = if_a.ready;
        if_a.value = 6'(v);
        if_a.load  = 1'b1;
        @(negedge clk);
        if_a.load  = 1'b0;
    endtask

    task automatic load_bc(input int v, output bit accepted);
        @(negedge clk);
        accepted   = if_b.ready & if_c.ready;
        if_b.value = 8'(v);
        if_c.value = 8'(v);
        if_b.load  = 1'b1;
        if_c.load  = 1'b1;
        @(negedge clk);
        if_b.load  = 1'b0;
        if_c.load  = 1'b0;
    endtask

    task automatic wait_ready_a(output int low_cycles);
        low_cycles = 0;
        while (!if_a.ready && low_cycles < 100) begin
            low_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic wait_ready_b(output int low_cycles);
        low_cycles = 0;
        while (!if_b.ready && low_cycles < 100) begin
            low_cycles++;
            @(negedge clk);
        end
    endtask

    // Observe one full scan pass of each digit; returns the last seg seen per digit.
    task automatic capture_a(output logic [6:0] s0, output logic [6:0] s1,
                             output int bad_an, output int busy);
        s0 = 'x; s1 = 'x; bad_an = 0; busy = 0;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            if (if_a.an == 2'b01)      s0 = if_a.seg;
            else if (if_a.an == 2'b10) s1 = if_a.seg;
            else                       bad_an++;
            if (!if_a.ready) busy++;
            @(negedge clk);
        end
    endtask

    task automatic capture_bc(output logic [6:0] b0, output logic [6:0] b1,
                              output logic [6:0] c0, output logic [6:0] c1,
                              output int bad_an);
        b0 = 'x; b1 = 'x; c0 = 'x; c1 = 'x; bad_an = 0;
        @(negedge clk);
        for (int k = 0; k < 14; k++) begin
            if (if_b.an == 2'b01)      b0 = if_b.seg;
            else if (if_b.an == 2'b10) b1 = if_b.seg;
            else                       bad_an++;
            if (if_c.an == 2'b01)      c0 = if_c.seg;
            else if (if_c.an == 2'b10) c1 = if_c.seg;
            else                       bad_an++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (if_a.seg !== 7'h00) begin errors++; $display("FAIL reset_seg got %h want 00", if_a.seg); end
        checks++;
        if (if_a.an !== 2'b00) begin errors++; $display("FAIL reset_an got %b want 00", if_a.an); end
        checks++;
        if (if_a.ready !== 1'b0 || if_a.ovf !== 1'b0) begin
            errors++; $display("FAIL reset_ready_ovf got %b%b want 00", if_a.ready, if_a.ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (if_a.ready !== 1'b1) begin errors++; $display("FAIL first_ready got %b want 1", if_a.ready); end
        checks++;
        if (if_a.an !== 2'b01) begin errors++; $display("FAIL first_an got %b want 01", if_a.an); end
        checks++;
        if (if_a.seg !== 7'h3F) begin errors++; $display("FAIL first_seg got %h want 3F", if_a.seg); end
        repeat (3) @(negedge clk);
        checks++;
        if (if_a.an !== 2'b01) begin errors++; $display("FAIL dwell_an got %b want 01", if_a.an); end
        @(negedge clk);
        checks++;
        if (if_a.an !== 2'b10) begin errors++; $display("FAIL scan_an got %b want 10", if_a.an); end
        checks++;
        if (if_a.seg !== 7'h00) begin errors++; $display("FAIL blank_tens got %h want 00", if_a.seg); end
    endtask

    task automatic test_load_47();
        bit acc; int low; logic [6:0] s0, s1; int bad, busy;
        load_a(47, acc);
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL load47_accept got %b want 1", acc); end
        wait_ready_a(low);
        checks++;
        if (low !== 7) begin errors++; $display("FAIL load47_busy got %0d want 7", low); end
        capture_a(s0, s1, bad, busy);
        checks++;
        if (s0 !== 7'h07) begin errors++; $display("FAIL load47_units got %h want 07", s0); end
        checks++;
        if (s1 !== 7'h66) begin errors++; $display("FAIL load47_tens got %h want 66", s1); end
        checks++;
        if (if_a.ovf !== 1'b0) begin errors++; $display("FAIL load47_ovf got %b want 0", if_a.ovf); end
    endtask

    task automatic test_sweep();
        int vals[64];
        bit acc; int low; logic [6:0] s0, s1; int bad, busy;
        for (int i = 0; i < 64; i++) vals[i] = i;
        for (int i = 63; i > 0; i--) begin
            int j = int'($urandom_range(i, 0));
            int t = vals[i];
            vals[i] = vals[j];
            vals[j] = t;
        end
        for (int i = 0; i < 64; i++) begin
            load_a(vals[i], acc);
            checks++;
            if (acc !== 1'b1) begin errors++; $display("FAIL sweep_accept v=%0d got %b want 1", vals[i], acc); end
            wait_ready_a(low);
            checks++;
            if (low !== 7) begin errors++; $display("FAIL sweep_busy v=%0d got %0d want 7", vals[i], low); end
            capture_a(s0, s1, bad, busy);
            checks++;
            if (s0 !== model_seg(vals[i], 2, 0, 1'b1)) begin
                errors++; $display("FAIL sweep_units v=%0d got %h want %h", vals[i], s0, model_seg(vals[i], 2, 0, 1'b1));
            end
            checks++;
            if (s1 !== model_seg(vals[i], 2, 1, 1'b1)) begin
                errors++; $display("FAIL sweep_tens v=%0d got %h want %h", vals[i], s1, model_seg(vals[i], 2, 1, 1'b1));
            end
            checks++;
            if (if_a.ovf !== model_ovf(vals[i], 2) || bad !== 0) begin
                errors++; $display("FAIL sweep_ovf_an v=%0d got ovf=%b bad_an=%0d want ovf=%b bad_an=0",
                                   vals[i], if_a.ovf, bad, model_ovf(vals[i], 2));
            end
        end
    endtask

    task automatic test_overflow();
        int vals[$];
        bit acc; int low; logic [6:0] b0, b1, c0, c1; int bad;
        vals.push_back(200);
        vals.push_back(5);
        vals.push_back(99);
        vals.push_back(100);
        for (int i = 0; i < 12; i++) vals.push_back(int'($urandom_range(255, 0)));
        foreach (vals[i]) begin
            load_bc(vals[i], acc);
            checks++;
            if (acc !== 1'b1) begin errors++; $display("FAIL ovf_accept v=%0d got %b want 1", vals[i], acc); end
            wait_ready_b(low);
            checks++;
            if (low !== 9) begin errors++; $display("FAIL ovf_busy v=%0d got %0d want 9", vals[i], low); end
            capture_bc(b0, b1, c0, c1, bad);
            checks++;
            if (if_b.ovf !== model_ovf(vals[i], 2) || if_c.ovf !== model_ovf(vals[i], 2)) begin
                errors++; $display("FAIL ovf_flag v=%0d got %b%b want %b", vals[i], if_b.ovf, if_c.ovf, model_ovf(vals[i], 2));
            end
            checks++;
            if (b0 !== model_seg(vals[i], 2, 0, 1'b1) || b1 !== model_seg(vals[i], 2, 1, 1'b1)) begin
                errors++; $display("FAIL ovf_blank_digits v=%0d got %h %h want %h %h", vals[i], b1, b0,
                                   model_seg(vals[i], 2, 1, 1'b1), model_seg(vals[i], 2, 0, 1'b1));
            end
            checks++;
            if (c0 !== model_seg(vals[i], 2, 0, 1'b0) || c1 !== model_seg(vals[i], 2, 1, 1'b0)) begin
                errors++; $display("FAIL ovf_noblank_digits v=%0d got %h %h want %h %h", vals[i], c1, c0,
                                   model_seg(vals[i], 2, 1, 1'b0), model_seg(vals[i], 2, 0, 1'b0));
            end
            checks++;
            if (bad !== 0) begin errors++; $display("FAIL ovf_an_onehot v=%0d got %0d bad want 0", vals[i], bad); end
        end
    endtask

    task automatic test_busy();
        bit acc; int low; logic [6:0] s0, s1; int bad, busy;
        load_a(59, acc);
        @(negedge clk);
        checks++;
        if (if_a.ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", if_a.ready); end
        if_a.value = 6'd12;
        if_a.load  = 1'b1;
        @(negedge clk);
        if_a.load  = 1'b0;
        wait_ready_a(low);
        checks++;
        if (low > 7) begin errors++; $display("FAIL busy_timeout got %0d want <=7", low); end
        capture_a(s0, s1, bad, busy);
        checks++;
        if (s0 !== 7'h6F || s1 !== 7'h6D) begin
            errors++; $display("FAIL busy_display got %h %h want 6D 6F", s1, s0);
        end
        checks++;
        if (busy !== 0) begin errors++; $display("FAIL busy_queued got %0d busy cycles want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit acc; logic [6:0] s0, s1; int bad, busy;
        load_a(33, acc);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (if_a.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", if_a.ready); end
        capture_a(s0, s1, bad, busy);
        checks++;
        if (s0 !== 7'h3F || s1 !== 7'h00) begin
            errors++; $display("FAIL midrst_display got %h %h want 00 3F", s1, s0);
        end
        checks++;
        if (if_a.ovf !== 1'b0 || busy !== 0) begin
            errors++; $display("FAIL midrst_state got ovf=%b busy=%0d want ovf=0 busy=0", if_a.ovf, busy);
        end
    endtask

    initial begin
        if_a.value = '0; if_a.load = 1'b0;
        if_b.value = '0; if_b.load = 1'b0;
        if_c.value = '0; if_c.load = 1'b0;
        test_reset();
        test_load_47();
        test_sweep();
        test_overflow();
        test_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
